// File: rtl/buffer_unit_vc_if.sv
// Link bundle for buffer_unit_vc: input link, crossbar link, allocator and status.
// slave is the buffer side, master is the upstream/downstream/allocator side.
interface buffer_unit_vc_if #(
    parameter int DATA_WIDTH   = 18,
    parameter int ADDRESS_SIZE = 4,
    parameter int NUM_VC       = 2
);
    localparam int VC_W = (NUM_VC > 1) ? $clog2(NUM_VC) : 1;

    logic                           in_req;
    logic [VC_W-1:0]                in_vc;
    logic [DATA_WIDTH-1:0]          in_data;
    logic                           in_ack;
    logic                           out_req;
    logic [VC_W-1:0]                out_vc;
    logic [DATA_WIDTH-1:0]          out_data;
    logic                           out_ack;
    logic [NUM_VC-1:0]              sa_req;
    logic [NUM_VC-1:0]              sa_grant;
    logic [NUM_VC*ADDRESS_SIZE-1:0] dest;
    logic                           err;

    modport slave (
        input  in_req, in_vc, in_data, out_ack, sa_grant,
        output in_ack, out_req, out_vc, out_data, sa_req, dest, err
    );

    modport master (
        output in_req, in_vc, in_data, out_ack, sa_grant,
        input  in_ack, out_req, out_vc, out_data, sa_req, dest, err
    );
endinterface

// File: rtl/buffer_unit_vc.sv
// Router input buffer: per-VC flit FIFOs, switch-allocator requests, 4-phase links.
// Store-and-forward by default; define BUFFER_UNIT_CUT_THROUGH_EN for cut-through.
`ifndef FLIT_HEADER
`define FLIT_HEADER 2'b01
`endif
`ifndef FLIT_BODY
`define FLIT_BODY 2'b00
`endif
`ifndef FLIT_TAIL
`define FLIT_TAIL 2'b10
`endif

module buffer_unit_vc #(
    parameter int DATA_WIDTH   = 18,
    parameter int FIFO_DEPTH   = 16,
    parameter int ADDRESS_SIZE = 4,
    parameter int NUM_VC       = 2
) (
    input logic             clk,
    input logic             rst,
    buffer_unit_vc_if.slave bus
);
    localparam int VC_W = (NUM_VC > 1) ? $clog2(NUM_VC) : 1;
    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int PW   = AW + 1;
    localparam int CW   = AW + 1;

    typedef enum logic {I_IDLE, I_ACK} i_state_e;
    typedef enum logic [1:0] {V_IDLE, V_REQ, V_ACTIVE} v_state_e;
    typedef enum logic [1:0] {O_IDLE, O_REQ, O_DROP} o_state_e;

    logic [DATA_WIDTH-1:0]   mem_q [NUM_VC][FIFO_DEPTH];
    logic [PW-1:0]           wr_ptr_q [NUM_VC];
    logic [PW-1:0]           wr_ptr_d [NUM_VC];
    logic [PW-1:0]           rd_ptr_q [NUM_VC];
    logic [PW-1:0]           rd_ptr_d [NUM_VC];
    logic [CW-1:0]           pkt_cnt_q [NUM_VC];
    logic [CW-1:0]           pkt_cnt_d [NUM_VC];
    v_state_e                v_state_q [NUM_VC];
    v_state_e                v_state_d [NUM_VC];
    logic [ADDRESS_SIZE-1:0] dest_q [NUM_VC];
    logic [ADDRESS_SIZE-1:0] dest_d [NUM_VC];
    logic [ADDRESS_SIZE-1:0] shadow_q [NUM_VC];
    logic [ADDRESS_SIZE-1:0] shadow_d [NUM_VC];
    logic [NUM_VC-1:0]       shadow_vld_q, shadow_vld_d;

    i_state_e              i_state_q, i_state_d;
    o_state_e              o_state_q, o_state_d;
    logic [VC_W-1:0]       out_vc_q, out_vc_d;
    logic [VC_W-1:0]       rr_q, rr_d;
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic                  out_req_q, out_req_d;
    logic                  err_q, err_d;

    logic [NUM_VC-1:0]     full, empty, wr_en, pop, elig, pkt_ready;
    logic [NUM_VC-1:0]     hdr_wr, tail_wr, tail_pop, busy;
    logic [DATA_WIDTH-1:0] head [NUM_VC];
    logic [1:0]            in_type, out_type;
    logic                  vc_ok, bad_vc, found;
    logic [VC_W-1:0]       win;

    assign in_type  = bus.in_data[DATA_WIDTH-1:DATA_WIDTH-2];
    assign out_type = out_data_q[DATA_WIDTH-1:DATA_WIDTH-2];
    assign vc_ok    = int'(bus.in_vc) < NUM_VC;

    // Extra pointer bit separates full from empty when the indices match.
    always_comb begin
        for (int v = 0; v < NUM_VC; v++) begin
            empty[v] = wr_ptr_q[v] == rd_ptr_q[v];
            full[v]  = (wr_ptr_q[v][AW-1:0] == rd_ptr_q[v][AW-1:0]) &&
                       (wr_ptr_q[v][AW] != rd_ptr_q[v][AW]);
            head[v]  = mem_q[v][rd_ptr_q[v][AW-1:0]];
            elig[v]  = (v_state_q[v] == V_ACTIVE) && !empty[v];
`ifdef BUFFER_UNIT_CUT_THROUGH_EN
            pkt_ready[v] = 1'b1;
`else
            pkt_ready[v] = pkt_cnt_q[v] != '0;
`endif
        end
    end

    always_comb begin
        i_state_d = i_state_q;
        wr_en     = '0;
        bad_vc    = 1'b0;
        unique case (i_state_q)
            I_IDLE: begin
                if (bus.in_req) begin
                    if (!vc_ok) begin
                        bad_vc    = 1'b1;
                        i_state_d = I_ACK;
                    end else if (!full[bus.in_vc]) begin
                        wr_en[bus.in_vc] = 1'b1;
                        i_state_d        = I_ACK;
                    end
                end
            end
            I_ACK: begin
                if (!bus.in_req) i_state_d = I_IDLE;
            end
            default: i_state_d = I_IDLE;
        endcase
    end

    always_comb begin
        for (int v = 0; v < NUM_VC; v++) begin
            hdr_wr[v]   = wr_en[v] && (in_type == `FLIT_HEADER);
            tail_wr[v]  = wr_en[v] && (in_type == `FLIT_TAIL);
            tail_pop[v] = pop[v] && (out_type == `FLIT_TAIL);
            busy[v]     = (v_state_q[v] != V_IDLE) || !empty[v];

            wr_ptr_d[v]  = wr_ptr_q[v] + {{(PW-1){1'b0}}, wr_en[v]};
            rd_ptr_d[v]  = rd_ptr_q[v] + {{(PW-1){1'b0}}, pop[v]};
            pkt_cnt_d[v] = pkt_cnt_q[v] + {{(CW-1){1'b0}}, tail_wr[v]}
                                        - {{(CW-1){1'b0}}, tail_pop[v]};

            // Next packet's destination waits in the shadow until this tail leaves.
            dest_d[v]       = dest_q[v];
            shadow_d[v]     = shadow_q[v];
            shadow_vld_d[v] = shadow_vld_q[v];
            if (tail_pop[v] && shadow_vld_q[v]) begin
                dest_d[v]       = shadow_q[v];
                shadow_vld_d[v] = 1'b0;
            end
            if (hdr_wr[v]) begin
                if (busy[v] && !(tail_pop[v] && !shadow_vld_q[v])) begin
                    shadow_d[v]     = bus.in_data[ADDRESS_SIZE-1:0];
                    shadow_vld_d[v] = 1'b1;
                end else begin
                    dest_d[v] = bus.in_data[ADDRESS_SIZE-1:0];
                end
            end

            v_state_d[v] = v_state_q[v];
            unique case (v_state_q[v])
                V_IDLE: begin
                    if (!empty[v] && pkt_ready[v] &&
                        head[v][DATA_WIDTH-1:DATA_WIDTH-2] == `FLIT_HEADER)
                        v_state_d[v] = V_REQ;
                end
                V_REQ: begin
                    if (bus.sa_grant[v]) v_state_d[v] = V_ACTIVE;
                end
                V_ACTIVE: begin
                    if (tail_pop[v]) v_state_d[v] = V_IDLE;
                end
                default: v_state_d[v] = V_IDLE;
            endcase
        end
    end

    always_comb begin
        found = 1'b0;
        win   = '0;
        for (int i = 0; i < NUM_VC; i++) begin
            int idx;
            idx = (int'(rr_q) + i) % NUM_VC;
            if (!found && elig[idx]) begin
                found = 1'b1;
                win   = VC_W'(idx);
            end
        end
    end

    always_comb begin
        o_state_d  = o_state_q;
        out_req_d  = out_req_q;
        out_vc_d   = out_vc_q;
        out_data_d = out_data_q;
        rr_d       = rr_q;
        pop        = '0;
        unique case (o_state_q)
            O_IDLE: begin
                if (found) begin
                    out_vc_d   = win;
                    out_data_d = head[win];
                    out_req_d  = 1'b1;
                    rr_d       = (int'(win) == NUM_VC - 1) ? '0 : win + 1'b1;
                    o_state_d  = O_REQ;
                end
            end
            O_REQ: begin
                if (bus.out_ack) begin
                    pop[out_vc_q] = 1'b1;
                    out_req_d     = 1'b0;
                    o_state_d     = O_DROP;
                end
            end
            O_DROP: begin
                if (!bus.out_ack) o_state_d = O_IDLE;
            end
            default: o_state_d = O_IDLE;
        endcase
    end

    // A packet longer than the FIFO can never complete in store-and-forward.
    always_comb begin
        err_d = err_q || bad_vc;
`ifndef BUFFER_UNIT_CUT_THROUGH_EN
        for (int v = 0; v < NUM_VC; v++) begin
            if (full[v] && pkt_cnt_q[v] == '0) err_d = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk) begin
        for (int v = 0; v < NUM_VC; v++) begin
            if (wr_en[v]) mem_q[v][wr_ptr_q[v][AW-1:0]] <= bus.in_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            i_state_q    <= I_IDLE;
            o_state_q    <= O_IDLE;
            out_vc_q     <= '0;
            out_data_q   <= '0;
            out_req_q    <= 1'b0;
            rr_q         <= '0;
            err_q        <= 1'b0;
            shadow_vld_q <= '0;
            for (int v = 0; v < NUM_VC; v++) begin
                wr_ptr_q[v]  <= '0;
                rd_ptr_q[v]  <= '0;
                pkt_cnt_q[v] <= '0;
                v_state_q[v] <= V_IDLE;
                dest_q[v]    <= '0;
                shadow_q[v]  <= '0;
            end
        end else begin
            i_state_q    <= i_state_d;
            o_state_q    <= o_state_d;
            out_vc_q     <= out_vc_d;
            out_data_q   <= out_data_d;
            out_req_q    <= out_req_d;
            rr_q         <= rr_d;
            err_q        <= err_d;
            shadow_vld_q <= shadow_vld_d;
            for (int v = 0; v < NUM_VC; v++) begin
                wr_ptr_q[v]  <= wr_ptr_d[v];
                rd_ptr_q[v]  <= rd_ptr_d[v];
                pkt_cnt_q[v] <= pkt_cnt_d[v];
                v_state_q[v] <= v_state_d[v];
                dest_q[v]    <= dest_d[v];
                shadow_q[v]  <= shadow_d[v];
            end
        end
    end

    assign bus.in_ack   = i_state_q == I_ACK;
    assign bus.out_req  = out_req_q;
    assign bus.out_vc   = out_vc_q;
    assign bus.out_data = out_data_q;
    assign bus.err      = err_q;

    always_comb begin
        bus.sa_req = '0;
        bus.dest   = '0;
        for (int v = 0; v < NUM_VC; v++) begin
            bus.sa_req[v]                           = v_state_q[v] != V_IDLE;
            bus.dest[v*ADDRESS_SIZE +: ADDRESS_SIZE] = dest_q[v];
        end
    end
endmodule
